// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps one read in flight to instruction memory and
// buffers returned words in a 2-entry {pc, instruction} FIFO for the decoder.
// Optional feature macro: FETCH_STALL_CNT_EN enables the saturating
// backpressure stall counter on o_stall_cnt; otherwise it reads 0.
module fetch_unit #(
    parameter type T = logic [31:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [8:0] imem_addr,
    input  T           imem_rdata,
    input  logic       i_redirect_valid,
    input  logic [8:0] i_redirect_pc,
    output T           o_instruction,
    output logic [8:0] o_pc,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [15:0] o_stall_cnt
);

    localparam int unsigned PC_W  = 9;
    localparam int unsigned CNT_W = 2;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic             rd_ptr;
    logic             wr_ptr;
    T                 fifo_instr [2];
    logic [PC_W-1:0]  fifo_pc    [2];

    logic             pop;
    logic             push;
    logic [CNT_W-1:0] occupancy;
    logic [PC_W-1:0]  redirect_addr;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    // Handshake, issue decision and head-of-FIFO view
    always_comb begin
        redirect_addr = {i_redirect_pc[8:2], 2'b00};
        o_valid       = rst_n && (count != '0) && !i_redirect_valid;
        pop           = o_valid && i_ready;
        push          = inflight && !i_redirect_valid;
        // Entries that will exist once this cycle settles, counting the in-flight read
        occupancy     = count + CNT_W'(inflight) - CNT_W'(pop);
        imem_req      = rst_n && (i_redirect_valid || (occupancy <= CNT_W'(1)));
        imem_addr     = i_redirect_valid ? redirect_addr : fetch_pc;
        o_instruction = fifo_instr[rd_ptr];
        o_pc          = fifo_pc[rd_ptr];
    end

    // Fetch PC, in-flight tracking and FIFO occupancy/pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + PC_W'(4);
            end
            if (i_redirect_valid) begin
                count  <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage: returning word is written with the pc it was fetched from
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Count cycles where the decoder holds off a valid instruction, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (o_valid && !i_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: address-indexed memory model plus a
// scoreboard of expected {pc, instruction} pairs, and directed timing checks.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        i_redirect_valid;
    logic [8:0]  i_redirect_pc;
    logic [31:0] o_instruction;
    logic [8:0]  o_pc;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd5;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_stall_cnt      (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    // Memory answers exactly one cycle after a request; garbage otherwise
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected entries pushed on issue, popped on accepted output
    typedef struct packed {
        logic [8:0]  pc;
        logic [31:0] instr;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    logic [8:0] exp_fetch_pc = 9'h000;

    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            sb_q.delete();
            exp_fetch_pc = 9'h000;
        end else begin
            if (i_redirect_valid) begin
                sb_q.delete();
                exp_fetch_pc = {i_redirect_pc[8:2], 2'b00};
                check("redirect_valid_low", 32'(o_valid), 32'd0);
            end
            if (imem_req) begin
                check("imem_addr_seq", 32'(imem_addr), 32'(exp_fetch_pc));
                sb_q.push_back({exp_fetch_pc, word_at(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 9'd4;
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_pop", 32'(o_pc), 32'h1FF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", 32'(o_pc), 32'(e.pc));
                    check("sb_instr", o_instruction, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n            = 1'b0;
        i_ready          = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 9'h000;
        tick(); tick(); smp();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_stall", 32'(o_stall_cnt), 32'd0);

        // Reset release: addr 0 first, o_valid from cycle 2, one per cycle
        tick(); rst_n = 1'b1; smp();
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", 32'(imem_addr), 32'h000);
        tick(); smp();
        check("c1_valid", 32'(o_valid), 32'd0);
        check("c1_addr", 32'(imem_addr), 32'h004);
        tick(); smp();
        check("c2_valid", 32'(o_valid), 32'd1);
        check("c2_pc", 32'(o_pc), 32'h000);
        tick(); smp();
        check("c3_pc", 32'(o_pc), 32'h004);

        // Backpressure for 5 cycles with o_pc = 8
        tick(); i_ready = 1'b0; smp();
        check("stall_pc", 32'(o_pc), 32'h008);
        check("stall_req", 32'(imem_req), 32'd0);
        repeat (4) begin
            tick(); smp();
            check("stall_hold_pc", 32'(o_pc), 32'h008);
            check("stall_hold_valid", 32'(o_valid), 32'd1);
            check("stall_hold_req", 32'(imem_req), 32'd0);
        end
        tick(); i_ready = 1'b1; smp();
        check("resume_pc0", 32'(o_pc), 32'h008);
        check("stall_cnt", 32'(o_stall_cnt), 32'(EXP_STALL));
        tick(); smp();
        check("resume_pc1", 32'(o_pc), 32'h00C);
        tick(); smp();
        check("resume_pc2", 32'(o_pc), 32'h010);

        // Random backpressure exercised through the scoreboard
        repeat (24) begin
            tick(); i_ready = 1'($urandom_range(0, 1)); smp();
        end

        // Fill the FIFO then redirect to 0x0A2
        tick(); i_ready = 1'b0; smp();
        tick(); smp();
        tick(); smp();
        check("full_req", 32'(imem_req), 32'd0);
        check("full_valid", 32'(o_valid), 32'd1);
        tick(); i_ready = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 9'h0A2; smp();
        check("redir_valid", 32'(o_valid), 32'd0);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", 32'(imem_addr), 32'h0A0);
        tick(); i_redirect_valid = 1'b0; smp();
        check("redir_c1_valid", 32'(o_valid), 32'd0);
        tick(); smp();
        check("redir_c2_valid", 32'(o_valid), 32'd1);
        check("redir_pc0", 32'(o_pc), 32'h0A0);
        tick(); smp();
        check("redir_pc1", 32'(o_pc), 32'h0A4);

        // Address wrap near 0x1FF
        tick(); i_redirect_valid = 1'b1; i_redirect_pc = 9'h1F8; smp();
        tick(); i_redirect_valid = 1'b0; smp();
        tick(); smp();
        check("wrap_pc0", 32'(o_pc), 32'h1F8);
        tick(); smp();
        check("wrap_pc1", 32'(o_pc), 32'h1FC);
        tick(); smp();
        check("wrap_pc2", 32'(o_pc), 32'h000);
        check("wrap_instr", o_instruction, word_at(9'h000));

        // Mid-stream reset with two entries buffered
        tick(); i_ready = 1'b0; smp();
        tick(); smp();
        tick(); smp();
        tick(); rst_n = 1'b0; smp();
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_req", 32'(imem_req), 32'd0);
        tick(); rst_n = 1'b1; smp();
        check("post_rst_valid", 32'(o_valid), 32'd0);
        check("post_rst_stall", 32'(o_stall_cnt), 32'd0);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", 32'(imem_addr), 32'h000);
        tick(); i_ready = 1'b1; smp();
        tick(); smp();
        check("post_rst_pc0", 32'(o_pc), 32'h000);
        repeat (6) begin
            tick(); smp();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
